// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-outstanding access sequencer sharing a
// single-cycle big-endian data memory between two requesters.
//   state  | meaning
//   IDLE   | arbitrate, accept one request
//   ACCESS | drive memory strobe, capture read data
//   RESP   | one-cycle response pulse to the granted requester
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 5120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Write_data,
    input  logic [DATA_W-1:0] Read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_id;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_hs;
    logic                w_req_we;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [DATA_W-1:0]   w_req_wdata;
    logic [ADDR_W+1:0]   w_end_addr;
    logic                w_req_err;
    logic                w_rsp;

    always_comb begin
        w_grant0    = req0_valid && (!req1_valid || r_last);
        w_grant1    = req1_valid && (!req0_valid || !r_last);
        req0_ready  = (r_state == S_IDLE) && w_grant0 && !reset;
        req1_ready  = (r_state == S_IDLE) && w_grant1 && !reset;
        w_hs        = req0_ready || req1_ready;
        w_req_we    = req1_ready ? req1_we    : req0_we;
        w_req_addr  = req1_ready ? req1_addr  : req0_addr;
        w_req_wdata = req1_ready ? req1_wdata : req0_wdata;
        // Extra headroom bits keep addresses near the top from wrapping into range.
        w_end_addr  = {2'b00, w_req_addr} + (ADDR_W+2)'(3);
        w_req_err   = w_end_addr > (ADDR_W+2)'(MEM_BYTES - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_hs) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_id    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_hs) begin
                r_last  <= req1_ready;
                r_id    <= req1_ready;
                r_we    <= w_req_we;
                r_addr  <= w_req_addr;
                r_wdata <= w_req_wdata;
                r_err   <= w_req_err;
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= (!r_we && !r_err) ? Read_data : '0;
            end
        end
    end

    always_comb begin
        MemWrite   = (r_state == S_ACCESS) && r_we && !r_err && !reset;
        MemRead    = (r_state == S_ACCESS) && !r_we && !r_err && !reset;
        Address    = r_addr;
        Write_data = r_wdata;
        w_rsp      = (r_state == S_RESP) && !reset;
        rsp0_valid = w_rsp && !r_id;
        rsp1_valid = w_rsp && r_id;
        rsp0_rdata = rsp0_valid ? r_rdata : '0;
        rsp1_rdata = rsp1_valid ? r_rdata : '0;
        rsp0_err   = rsp0_valid && r_err;
        rsp1_err   = rsp1_valid && r_err;
    end

endmodule
